// File: rtl/register_file_mp_if.sv
// Bundle of the read, write and clear signals between the pipeline and register_file_mp.
// The master is the core (decode/writeback side); the slave is the register file.
interface register_file_mp_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
);

   logic [NUM_RD*ADDR_W-1:0] rd_addr_i;
   logic [NUM_RD*DATA_W-1:0] rd_data_o;
   logic [ADDR_W-1:0]        wr_addr_i;
   logic [DATA_W-1:0]        wr_data_i;
   logic                     wr_enable_i;
   logic                     clr_i;
   logic                     ready_o;
   logic                     clr_busy_o;

   modport master (
      output rd_addr_i, wr_addr_i, wr_data_i, wr_enable_i, clr_i,
      input  rd_data_o, ready_o, clr_busy_o
   );

   modport slave (
      input  rd_addr_i, wr_addr_i, wr_data_i, wr_enable_i, clr_i,
      output rd_data_o, ready_o, clr_busy_o
   );

endinterface

// File: rtl/register_file_mp.sv
// Multi-read-port register file with optional write bypass, optional hardwired zero
// register and a clear engine that zeroes one register per cycle after reset or on request.
module register_file_mp #(
   parameter int DATA_W       = 32,
   parameter int NUM_REGS     = 32,
   parameter int ADDR_W       = 5,
   parameter int NUM_RD       = 2,
   parameter int WRITE_BYPASS = 1,
   parameter int ZERO_REG     = 1
) (
   input logic               clk,
   input logic               reset,
   register_file_mp_if.slave bus
);

   typedef enum logic {
      CLEAR,
      READY
   } state_e;

   localparam logic [ADDR_W:0] LastIdx = (ADDR_W+1)'(NUM_REGS - 1);

   state_e              state_q, state_d;
   logic [ADDR_W:0]     clrCnt_q, clrCnt_d;
   logic [DATA_W-1:0]   regs_q [NUM_REGS];

   logic                    wrLive;
   logic                    wrCommit;
   logic                    clrWrite;
   logic [ADDR_W-1:0]       ra;
   logic [DATA_W-1:0]       laneData;
   logic [NUM_RD*DATA_W-1:0] rdData;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= CLEAR;
         clrCnt_q <= '0;
      end else begin
         state_q  <= state_d;
         clrCnt_q <= clrCnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      clrCnt_d = clrCnt_q;
      case (state_q)
         CLEAR: begin
            clrCnt_d = clrCnt_q + (ADDR_W+1)'(1);
            if (clrCnt_q == LastIdx) begin
               state_d = READY;
            end
         end
         READY: begin
            if (bus.clr_i) begin
               state_d  = CLEAR;
               clrCnt_d = '0;
            end
         end
         default: begin
            state_d  = CLEAR;
            clrCnt_d = '0;
         end
      endcase
   end

   // A write to x0 is discarded when the zero register is hardwired, so it must not bypass either.
   assign wrLive   = bus.wr_enable_i && !((ZERO_REG != 0) && (bus.wr_addr_i == '0));
   assign wrCommit = (state_q == READY) && !reset && !bus.clr_i && wrLive;
   assign clrWrite = (state_q == CLEAR) && !reset;

   // The array has no reset; the clear engine owns its initialisation.
   always_ff @(posedge clk) begin
      if (clrWrite) begin
         regs_q[clrCnt_q[ADDR_W-1:0]] <= '0;
      end else if (wrCommit) begin
         regs_q[bus.wr_addr_i] <= bus.wr_data_i;
      end
   end

   always_comb begin
      rdData   = '0;
      ra       = '0;
      laneData = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         ra = bus.rd_addr_i[k*ADDR_W +: ADDR_W];
         if (state_q == CLEAR) begin
            laneData = '0;
         end else if ((ZERO_REG != 0) && (ra == '0)) begin
            laneData = '0;
         end else if ((WRITE_BYPASS != 0) && wrLive && (ra == bus.wr_addr_i)) begin
            laneData = bus.wr_data_i;
         end else begin
            laneData = regs_q[ra];
         end
         rdData[k*DATA_W +: DATA_W] = laneData;
      end
   end

   assign bus.rd_data_o  = rdData;
   assign bus.ready_o    = (state_q == READY);
   assign bus.clr_busy_o = (state_q == CLEAR);

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised successor to the single-write, two-read integer register file used by the RISC-V core.
- Generalised in data width, register count and number of read ports.
- Adds three behaviours:
  - optional write-to-read bypass;
  - optional hardwired zero register;
  - a hardware clear engine that zeroes every register, one per cycle, after reset or on request.
- Sits between the decode stage (read addresses) and the writeback stage (write port). The core stalls while ready_o is low.

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 32, number of registers; power of two, at least 2.
- ADDR_W, 5, address width; must equal clog2(NUM_REGS).
- NUM_RD, 2, number of read ports, 1 to 4.
- WRITE_BYPASS, 1, if 1 a read returns the write data when it hits the write in progress in the same cycle.
- ZERO_REG, 1, if 1 register 0 always reads 0 and writes to it are discarded.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- rd_addr_i  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data_o  out  NUM_RD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W].
- wr_addr_i  in  ADDR_W  write address.
- wr_data_i  in  DATA_W  write data.
- wr_enable_i  in  1  write strobe.
- clr_i  in  1  clear request; sampled only when in READY.
- ready_o  out  1  high when the file is usable (READY state).
- clr_busy_o  out  1  high while the clear engine runs.

Behaviour:
- State machine: CLEAR and READY.
- Clear counter clr_cnt is ADDR_W+1 bits wide.
- Reset asserted, asynchronously:
  - state <= CLEAR, clr_cnt <= 0;
  - ready_o = 0, clr_busy_o = 1;
  - register array contents are not touched by reset itself.
- CLEAR state, each clock:
  - registers[clr_cnt] <= 0 and clr_cnt increments;
  - when clr_cnt == NUM_REGS-1 the state moves to READY on that edge;
  - the full clear therefore takes exactly NUM_REGS cycles after reset deasserts.
- In CLEAR:
  - wr_enable_i is ignored, with no deferred write;
  - every rd_data_o lane = 0;
  - clr_i is ignored.
- READY state:
  - ready_o = 1, clr_busy_o = 0.
  - clr_i = 1 at an edge moves the state to CLEAR with clr_cnt <= 0 and starts a full NUM_REGS-cycle clear.
  - A write presented in the same cycle as clr_i is dropped; clear wins.
- Write, in READY with wr_enable_i = 1:
  - registers[wr_addr_i] <= wr_data_i at the rising edge;
  - if ZERO_REG = 1 and wr_addr_i == 0, the write is discarded.
- Read (combinational, zero latency), per lane k:
  - In CLEAR, the lane reads 0.
  - Otherwise, if ZERO_REG = 1 and the address is 0, it reads 0.
  - Otherwise, if WRITE_BYPASS = 1, wr_enable_i = 1 and the address equals wr_addr_i, it reads wr_data_i. This only applies to a write that is not discarded.
  - Otherwise it reads registers[address].
- Lanes are independent. Any number of lanes may read the same address in the same cycle.
- With WRITE_BYPASS = 0, a read of a register being written that cycle returns the old value; the new value is visible from the next cycle.
- Reset asserted mid-clear restarts the clear from index 0.
- Reset asserted in READY discards any write at that edge.
- No output depends on clr_i combinationally.
- Addresses at or above NUM_REGS are impossible by construction, since NUM_REGS is a power of two.

Test Plan:
- Reset release, 40 cycles: ready_o low for exactly 32 cycles, then high; all 32 registers read back 0 on lane 0.
- READY: write 0xDEADBEEF to x5, then read x5 on lanes 0 and 1 the next cycle: both read 0xDEADBEEF. Write 0x1234 to x0: x0 still reads 0.
- WRITE_BYPASS=1: write 0xA5A5A5A5 to x7 while lane 1 reads x7 in the same cycle: lane 1 = 0xA5A5A5A5 that cycle. Rerun with WRITE_BYPASS=0: the old value is seen, and the new value appears the next cycle.
- Fill x1..x31 with their own index. Pulse clr_i together with a write of 0xFF to x3: clr_busy_o high for 32 cycles, then all registers read 0 and x3 ≠ 0xFF.
- Assert reset at clear cycle 10, hold 2 cycles, release: ready_o rises exactly 32 cycles after release. Writes issued during CLEAR have no effect afterwards.
- Parameter sweep: DATA_W=64, NUM_REGS=16, ADDR_W=4, NUM_RD=3, ZERO_REG=0. Write 0x0123456789ABCDEF to x0: x0 reads it back on all 3 lanes, and the clear takes 16 cycles.
